// File: rtl/divider_req_sequencer.sv
// -----------------------------------------------------------------------------
// divider_req_sequencer
//   Front-end for the 32/17 rounding unsigned divider. Operand pairs are queued
//   in a small FIFO, launched one at a time (Start held for START_W cycles),
//   and the rounded quotient returned by the divider is held in an output
//   register until the consumer takes it. A zero divisor is answered locally
//   with an all-ones quotient and err=1. A missing Finish produces q=0, err=1
//   once TIMEOUT cycles have passed since Start rose.
//
// Ports
//   Clk_i, Rst_i               clock, asynchronous active-high reset
//   In_valid_i/In_ready_o      request handshake, operands In_z_i / In_d_i
//   Div_start_o/Div_z_o/Div_d_o  drive the divider's Start/Z/D pins
//   Div_q_i/Div_finish_i       quotient and 1-cycle completion pulse from divider
//   Out_valid_o/Out_ready_i    result handshake, Out_q_o / Out_err_o
// -----------------------------------------------------------------------------
module divider_req_sequencer #(
  parameter int Z_L     = 32,
  parameter int D_L     = 17,
  parameter int DEPTH   = 4,
  parameter int START_W = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic               In_valid_i,
  output logic               In_ready_o,
  input  logic [Z_L-1:0]     In_z_i,
  input  logic [D_L-1:0]     In_d_i,
  output logic               Div_start_o,
  output logic [Z_L-1:0]     Div_z_o,
  output logic [D_L-1:0]     Div_d_o,
  input  logic [Z_L-D_L:0]   Div_q_i,
  input  logic               Div_finish_i,
  output logic               Out_valid_o,
  input  logic               Out_ready_i,
  output logic [Z_L-D_L:0]   Out_q_o,
  output logic               Out_err_o
);

  localparam int Q_L = Z_L - D_L + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW  = $clog2(START_W + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t state_reg, state_next;

  // Request FIFO: operand pairs stored as {z, d}
  logic [Z_L+D_L-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [Z_L-1:0]     head_z;
  logic [D_L-1:0]     head_d;

  logic [SW-1:0]      start_cnt_reg;
  logic [TW-1:0]      tmo_cnt_reg;
  logic [Z_L-1:0]     div_z_reg;
  logic [D_L-1:0]     div_d_reg;
  logic               out_valid_reg, out_err_reg;
  logic [Q_L-1:0]     out_q_reg;

  logic               launch_zero, capture_ok, capture_tmo;

  assign fifo_full  = (count_reg == (AW+1)'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  // A full FIFO refuses the push even if a pop happens in the same cycle.
  assign push       = In_valid_i && !fifo_full;
  assign {head_z, head_d} = fifo_mem[rd_ptr_reg];

  assign In_ready_o  = !fifo_full;
  // Decoded from the state register so the async reset drops it at once.
  assign Div_start_o = (state_reg == START);
  assign Div_z_o     = div_z_reg;
  assign Div_d_o     = div_d_reg;
  assign Out_valid_o = out_valid_reg;
  assign Out_q_o     = out_q_reg;
  assign Out_err_o   = out_err_reg;

  // Next-state and control strobes
  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    launch_zero = 1'b0;
    capture_ok  = 1'b0;
    capture_tmo = 1'b0;
    case (state_reg)
      IDLE: begin
        // Only launch once the previous result has left the output register.
        if (!fifo_empty && !out_valid_reg) begin
          pop = 1'b1;
          if (head_d == '0) launch_zero = 1'b1;
          else              state_next  = START;
        end
      end
      START: begin
        if (start_cnt_reg == SW'(START_W - 1)) state_next = WAIT;
      end
      WAIT: begin
        // Finish takes priority over a simultaneous timeout.
        if (Div_finish_i) begin
          capture_ok = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt_reg >= TW'(TIMEOUT - 1)) begin
          capture_tmo = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO storage has no reset so it can map onto RAM.
  always_ff @(posedge Clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= {In_z_i, In_d_i};
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      start_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      div_z_reg     <= '0;
      div_d_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_q_reg     <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      // Operands stay put from one pop to the next; the divider samples
      // them late, well after Start.
      if (pop) begin
        div_z_reg     <= head_z;
        div_d_reg     <= head_d;
        start_cnt_reg <= '0;
        tmo_cnt_reg   <= '0;
      end else begin
        if (state_reg == START) start_cnt_reg <= start_cnt_reg + 1'b1;
        // Counts cycles since Start rose, through START and WAIT.
        if (state_reg != IDLE)  tmo_cnt_reg   <= tmo_cnt_reg + 1'b1;
      end

      if (launch_zero) begin
        out_valid_reg <= 1'b1;
        out_q_reg     <= '1;
        out_err_reg   <= 1'b1;
      end else if (capture_ok) begin
        out_valid_reg <= 1'b1;
        out_q_reg     <= Div_q_i;
        out_err_reg   <= 1'b0;
      end else if (capture_tmo) begin
        out_valid_reg <= 1'b1;
        out_q_reg     <= '0;
        out_err_reg   <= 1'b1;
      end else if (out_valid_reg && Out_ready_i) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_divider_req_sequencer
//   Directed plus randomized bench for divider_req_sequencer. A behavioural
//   divider stub answers each Start after a fixed latency with the rounded
//   quotient of the operands it sees at that moment; a queue of expected
//   results is filled from the arithmetic reference as requests are accepted.
// -----------------------------------------------------------------------------
module tb_divider_req_sequencer;

  localparam int Z_L      = 32;
  localparam int D_L      = 17;
  localparam int Q_L      = Z_L - D_L + 1;
  localparam int DEPTH    = 4;
  localparam int START_W  = 2;
  localparam int TIMEOUT  = 64;
  localparam int STUB_LAT = Z_L - D_L + 5;

  logic             Clk_i;
  logic             Rst_i;
  logic             In_valid_i;
  logic             In_ready_o;
  logic [Z_L-1:0]   In_z_i;
  logic [D_L-1:0]   In_d_i;
  logic             Div_start_o;
  logic [Z_L-1:0]   Div_z_o;
  logic [D_L-1:0]   Div_d_o;
  logic [Q_L-1:0]   Div_q_i = '0;
  logic             Div_finish_i;
  logic             Out_valid_o;
  logic             Out_ready_i;
  logic [Q_L-1:0]   Out_q_o;
  logic             Out_err_o;

  logic stub_fin = 1'b0;
  logic stray_fin = 1'b0;
  logic stub_enable = 1'b1;
  assign Div_finish_i = stub_fin | stray_fin;

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0, exp_starts = 0;
  int overlap_err = 0, unstable_err = 0, burst_bad = 0;
  logic [Q_L:0] exp_q [$];   // {err, q}

  divider_req_sequencer #(
    .Z_L(Z_L), .D_L(D_L), .DEPTH(DEPTH), .START_W(START_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i),
    .In_valid_i(In_valid_i), .In_ready_o(In_ready_o),
    .In_z_i(In_z_i), .In_d_i(In_d_i),
    .Div_start_o(Div_start_o), .Div_z_o(Div_z_o), .Div_d_o(Div_d_o),
    .Div_q_i(Div_q_i), .Div_finish_i(Div_finish_i),
    .Out_valid_o(Out_valid_o), .Out_ready_i(Out_ready_i),
    .Out_q_o(Out_q_o), .Out_err_o(Out_err_o)
  );

  initial begin
    Clk_i = 1'b0;
    forever #5 Clk_i = ~Clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  // Rounded unsigned division: +1 when remainder exceeds D>>1; D==0 -> err.
  function automatic logic [Q_L:0] ref_div(input logic [Z_L-1:0] z, input logic [D_L-1:0] d);
    longint unsigned zz, dd, q, r;
    logic [Q_L-1:0] qq;
    if (d == '0) return {1'b1, {Q_L{1'b1}}};
    zz = z; dd = d;
    q = zz / dd;
    r = zz % dd;
    if (r > (dd >> 1)) q = q + 1;
    qq = q[Q_L-1:0];
    return {1'b0, qq};
  endfunction

  // Divider stub: one pending divide at a time, Finish STUB_LAT cycles after
  // Start rises. Also audits Start burst length and operand stability.
  logic             start_prev = 1'b0;
  logic             pend = 1'b0;
  int               wait_cnt = 0;
  int               hi_cnt = 0;
  logic [Z_L-1:0]   lz;
  logic [D_L-1:0]   ld;
  logic [Q_L:0]     stub_r;
  always @(negedge Clk_i) begin
    if (Rst_i) begin
      pend = 1'b0; wait_cnt = 0; hi_cnt = 0; start_prev = 1'b0; stub_fin = 1'b0;
    end else begin
      stub_fin = 1'b0;
      if (Div_start_o && !start_prev) begin
        n_starts++;
        if (pend) overlap_err++;
        pend = stub_enable; wait_cnt = 0; lz = Div_z_o; ld = Div_d_o;
      end else if (pend) begin
        wait_cnt++;
        if (wait_cnt == STUB_LAT) begin
          if (Div_z_o !== lz || Div_d_o !== ld) unstable_err++;
          stub_r   = ref_div(Div_z_o, Div_d_o);
          Div_q_i  = stub_r[Q_L-1:0];
          stub_fin = 1'b1;
          pend     = 1'b0;
        end
      end
      if (Div_start_o) hi_cnt++;
      else if (hi_cnt != 0) begin
        if (hi_cnt != START_W) burst_bad++;
        hi_cnt = 0;
      end
      start_prev = Div_start_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge (or after max_cyc refused cycles).
  task automatic send(input logic [Z_L-1:0] z, input logic [D_L-1:0] d,
                      input int max_cyc, input bit exp_tmo, output bit acc);
    acc = 1'b0;
    In_valid_i = 1'b1; In_z_i = z; In_d_i = d;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      if (In_ready_o === 1'b1) acc = 1'b1;
      @(negedge Clk_i);
    end
    In_valid_i = 1'b0;
    if (acc) begin
      if (exp_tmo)      exp_q.push_back({1'b1, {Q_L{1'b0}}});
      else              exp_q.push_back(ref_div(z, d));
      if (d != '0) exp_starts++;
    end
    $display("send z=%0h d=%0h accepted=%0d", z, d, acc);
  endtask

  task automatic get_results(input int n, input int max_cyc, input string tag);
    int got;
    logic [Q_L:0] e;
    got = 0;
    Out_ready_i = 1'b1;
    for (int c = 0; c < max_cyc && got < n; c++) begin
      if (Out_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_result"}, 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          $display("result %s q=%0h err=%0d expect q=%0h err=%0d", tag, Out_q_o, Out_err_o, e[Q_L-1:0], e[Q_L]);
          check({tag, "_q"}, 64'(Out_q_o), 64'(e[Q_L-1:0]));
          check({tag, "_err"}, 64'(Out_err_o), 64'(e[Q_L]));
        end
        got++;
      end
      @(negedge Clk_i);
    end
    Out_ready_i = 1'b0;
    check({tag, "_count"}, 64'(got), 64'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(Out_valid_o), 64'd0);
    check({tag, "_in_ready"},  64'(In_ready_o),  64'd1);
    check({tag, "_start"},     64'(Div_start_o), 64'd0);
    check({tag, "_div_z"},     64'(Div_z_o),     64'd0);
    check({tag, "_div_d"},     64'(Div_d_o),     64'd0);
    check({tag, "_out_q"},     64'(Out_q_o),     64'd0);
    check({tag, "_out_err"},   64'(Out_err_o),   64'd0);
  endtask

  bit               acc;
  int               cnt, lat, nb, snap;
  longint unsigned  q0, rr;
  logic [Z_L-1:0]   z;
  logic [D_L-1:0]   d;

  initial begin
    Rst_i = 1'b1; In_valid_i = 1'b0; In_z_i = '0; In_d_i = '0; Out_ready_i = 1'b0;
    repeat (3) @(negedge Clk_i);
    check_reset_outputs("por");
    Rst_i = 1'b0;
    @(negedge Clk_i);

    // Basic divides
    send(32'd1000, 17'd7, 10, 1'b0, acc);
    check("t1_accept", 64'(acc), 64'd1);
    get_results(1, 100, "t1");
    check("t1_starts", 64'(n_starts), 64'd1);
    send(32'd100, 17'd8, 10, 1'b0, acc);
    get_results(1, 100, "t2a");
    send(32'hFFFF_FFFF, 17'h1FFFF, 10, 1'b0, acc);
    get_results(1, 100, "t2b");

    // Divide by zero: local answer, no Start
    snap = n_starts;
    send(32'd5, 17'd0, 10, 1'b0, acc);
    lat = 1;
    while (Out_valid_o !== 1'b1 && lat < 10) begin @(negedge Clk_i); lat++; end
    check("t3_latency_le2", 64'(lat <= 2), 64'd1);
    check("t3_no_start", 64'(n_starts), 64'(snap));
    get_results(1, 10, "t3");

    // Backpressure: held result blocks launches, FIFO fills to DEPTH
    send(32'd5, 17'd0, 10, 1'b0, acc);
    repeat (3) @(negedge Clk_i);
    check("t4_held_valid", 64'(Out_valid_o), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      d = 17'($urandom_range(1, 131071));
      z = 32'($urandom_range(0, 32767)) * 32'(d);
      send(z, d, 1, 1'b0, acc);
      check("t4_accept", 64'(acc), 64'd1);
    end
    send(32'd77, 17'd3, 1, 1'b0, acc);
    check("t4_fifth_refused", 64'(acc), 64'd0);
    check("t4_in_ready_low", 64'(In_ready_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("t4_stable_q", 64'(Out_q_o), 64'hFFFF);
      check("t4_stable_err", 64'(Out_err_o), 64'd1);
      @(negedge Clk_i);
    end
    get_results(DEPTH + 1, 600, "t4");

    // Randomized batches
    for (int b = 0; b < 6; b++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          d = '0;
          z = $urandom;
        end else begin
          d  = 17'($urandom_range(1, 131071));
          q0 = $urandom_range(0, 32767);
          rr = $urandom_range(0, int'(d) - 1);
          z  = 32'(q0 * longint'(d) + rr);
        end
        send(z, d, 50, 1'b0, acc);
        check("rand_accept", 64'(acc), 64'd1);
      end
      get_results(nb, 40 * nb + 20, "rand");
    end

    // Timeout: stub never answers
    stub_enable = 1'b0;
    send(32'd1000, 17'd7, 10, 1'b1, acc);
    cnt = 0;
    while (Div_start_o !== 1'b1 && cnt < 10) begin @(negedge Clk_i); cnt++; end
    check("t5_start_seen", 64'(Div_start_o), 64'd1);
    cnt = 0;
    while (Out_valid_o !== 1'b1 && cnt < TIMEOUT + 20) begin @(negedge Clk_i); cnt++; end
    check("t5_timeout_window", 64'(cnt >= TIMEOUT - 1 && cnt <= TIMEOUT + 2), 64'd1);
    get_results(1, 10, "t5");
    stub_enable = 1'b1;

    // Stray Finish in IDLE must not produce a result
    stray_fin = 1'b1;
    @(negedge Clk_i);
    stray_fin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t5_stray_no_valid", 64'(Out_valid_o), 64'd0);
      @(negedge Clk_i);
    end

    check("starts_total", 64'(n_starts), 64'(exp_starts));

    // Reset during WAIT with more requests queued
    send(32'd1000, 17'd7, 10, 1'b0, acc);
    send(32'd2000, 17'd9, 10, 1'b0, acc);
    send(32'd3000, 17'd11, 10, 1'b0, acc);
    cnt = 0;
    while (Div_start_o !== 1'b1 && cnt < 10) begin @(negedge Clk_i); cnt++; end
    while (Div_start_o !== 1'b0 && cnt < 20) begin @(negedge Clk_i); cnt++; end
    repeat (3) @(negedge Clk_i);
    #2 Rst_i = 1'b1;
    #1 check_reset_outputs("t6_mid_reset");
    exp_q.delete();
    @(negedge Clk_i);
    @(negedge Clk_i);
    Rst_i = 1'b0;
    snap = n_starts;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk_i);
      check("t6_flushed_no_valid", 64'(Out_valid_o), 64'd0);
    end
    check("t6_flushed_no_start", 64'(n_starts), 64'(snap));
    send(32'd100, 17'd8, 10, 1'b0, acc);
    get_results(1, 100, "t6_after");
    check("t6_one_start", 64'(n_starts), 64'(snap + 1));

    check("burst_len", 64'(burst_bad), 64'd0);
    check("overlap", 64'(overlap_err), 64'd0);
    check("operand_stable", 64'(unstable_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
